// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared types for the SRAM-to-UART transmit path.
// Transmit FSM states, top-level state header and default bit period.
package uart_tx_pkg;

  localparam int TX_CLOCK_FREQ = 50_000_000;
  localparam int TX_BAUD_RATE  = 115_200;
  localparam int TX_BAUD_DIV_DEFAULT =
    TX_CLOCK_FREQ / TX_BAUD_RATE;

  typedef enum logic [2:0] {
    S_TX_IDLE,
    S_TX_FETCH,
    S_TX_WAIT,
    S_TX_SEND_HI,
    S_TX_SEND_LO,
    S_TX_DONE
  } tx_state_type;

  // Top-level milestone states; the dump-to-host
  // phase runs while the top FSM sits in S_UART_TX.
  typedef enum logic [2:0] {
    S_TOP_IDLE,
    S_UART_RX,
    S_M1,
    S_M2,
    S_M3,
    S_UART_TX
  } top_state_type;

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer, one bit per BAUD_DIV clocks.
// Ports: Clock, Reset, Data/Valid in; Ready, TX, Idle out.
module uart_tx_byte
  import uart_tx_pkg::*;
#(
  parameter int BAUD_DIV = TX_BAUD_DIV_DEFAULT
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Data,
  input  logic       Valid,
  output logic       Ready,
  output logic       TX,
  output logic       Idle
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BAUD_DIV - 1);

  logic          r_busy;
  logic          r_tx;
  logic [8:0]    r_shift;
  logic [3:0]    r_bit;
  logic [CW-1:0] r_cnt;
  logic          w_last_clk;

  // Final clock of the stop bit: a new byte may load
  // here so its start bit follows with no gap.
  assign w_last_clk = r_busy && (r_bit == 4'd9)
                      && (r_cnt == LAST_CNT);
  assign Ready = !r_busy || w_last_clk;
  assign Idle  = !r_busy;
  assign TX    = r_tx;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_busy  <= 1'b0;
      r_tx    <= 1'b1;
      r_shift <= '0;
      r_bit   <= '0;
      r_cnt   <= '0;
    end else if (Valid && Ready) begin
      r_busy  <= 1'b1;
      r_tx    <= 1'b0;
      r_shift <= {1'b1, Data};
      r_bit   <= '0;
      r_cnt   <= '0;
    end else if (r_busy) begin
      if (r_cnt == LAST_CNT) begin
        r_cnt <= '0;
        if (r_bit == 4'd9) begin
          r_busy <= 1'b0;
          r_tx   <= 1'b1;
          r_bit  <= '0;
        end else begin
          r_bit   <= r_bit + 4'd1;
          r_tx    <= r_shift[0];
          r_shift <= {1'b1, r_shift[8:1]};
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_sram_tx_interface.sv
// uart_sram_tx_interface: streams SRAM words out as 8N1 bytes.
// Start/Start_address/Word_count in; SRAM port, UART_TX_O, Busy, Done out.
module uart_sram_tx_interface
  import uart_tx_pkg::*;
#(
  parameter int CLOCK_FREQ   = 50_000_000,
  parameter int BAUD_RATE    = 115_200,
  parameter int BAUD_DIV     = CLOCK_FREQ / BAUD_RATE,
  parameter int READ_LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  input  logic [17:0] Start_address,
  input  logic [17:0] Word_count,
  output logic [17:0] SRAM_address,
  output logic        SRAM_we_n,
  input  logic [15:0] SRAM_read_data,
  output logic        UART_TX_O,
  output logic        Busy,
  output logic        Done
);

  tx_state_type r_state;
  tx_state_type w_state_next;

  logic [17:0] r_addr;
  logic [17:0] r_remaining;
  logic [15:0] r_word_buf;
  logic [15:0] r_next_buf;
  logic        r_next_vld;
  logic        r_done;
  logic [READ_LATENCY:0] r_pipe;

  logic       w_valid;
  logic [7:0] w_data;
  logic       w_ready;
  logic       w_idle;
  logic       w_tx;
  logic       w_issue;
  logic       w_start_acc;
  logic       w_lo_acc;
  logic       w_last;

  assign w_last = (r_remaining == 18'd1);
  assign w_start_acc = (r_state == S_TX_IDLE) && Start
                       && (Word_count != 18'd0);

  assign SRAM_address = r_addr;
  assign SRAM_we_n    = 1'b1;
  assign UART_TX_O    = w_tx;
  assign Busy         = (r_state != S_TX_IDLE);
  assign Done         = r_done;

  uart_tx_byte #(
    .BAUD_DIV (BAUD_DIV)
  ) u_tx_byte (
    .Clock (Clock),
    .Reset (Reset),
    .Data  (w_data),
    .Valid (w_valid),
    .Ready (w_ready),
    .TX    (w_tx),
    .Idle  (w_idle)
  );

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_TX_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_valid      = 1'b0;
    w_data       = 8'h00;
    w_issue      = 1'b0;
    w_lo_acc     = 1'b0;
    unique case (r_state)
      S_TX_IDLE: begin
        if (Start) begin
          if (Word_count == 18'd0) begin
            w_state_next = S_TX_DONE;
          end else begin
            w_issue      = 1'b1;
            w_state_next = S_TX_FETCH;
          end
        end
      end
      S_TX_FETCH, S_TX_WAIT: begin
        if (r_pipe[READ_LATENCY])
          w_state_next = S_TX_SEND_HI;
        else
          w_state_next = S_TX_WAIT;
      end
      S_TX_SEND_HI: begin
        w_valid = 1'b1;
        w_data  = r_word_buf[15:8];
        if (w_ready) begin
          // Prefetch the next word while the low byte shifts.
          w_issue      = !w_last;
          w_state_next = S_TX_SEND_LO;
        end
      end
      S_TX_SEND_LO: begin
        // Hold the low byte until the prefetch has landed,
        // so word_buf never swaps in stale data.
        w_valid = w_last || r_next_vld;
        w_data  = r_word_buf[7:0];
        if (w_valid && w_ready) begin
          w_lo_acc = 1'b1;
          if (w_last) w_state_next = S_TX_DONE;
          else        w_state_next = S_TX_SEND_HI;
        end
      end
      S_TX_DONE: begin
        if (w_idle) w_state_next = S_TX_IDLE;
      end
      default: w_state_next = S_TX_IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_word_buf  <= '0;
      r_next_buf  <= '0;
      r_next_vld  <= 1'b0;
      r_pipe      <= '0;
      r_done      <= 1'b0;
    end else begin
      r_pipe <= {r_pipe[READ_LATENCY-1:0], w_issue};
      r_done <= (r_state == S_TX_DONE) && w_idle;
      if (w_start_acc) begin
        r_addr      <= Start_address;
        r_remaining <= Word_count;
      end else if (w_issue) begin
        r_addr <= r_addr + 18'd1;
      end
      if (r_pipe[READ_LATENCY]) begin
        if (r_state == S_TX_FETCH ||
            r_state == S_TX_WAIT) begin
          r_word_buf <= SRAM_read_data;
        end else begin
          r_next_buf <= SRAM_read_data;
          r_next_vld <= 1'b1;
        end
      end
      if (w_lo_acc) begin
        r_remaining <= r_remaining - 18'd1;
        r_word_buf  <= r_next_buf;
        r_next_vld  <= 1'b0;
      end
    end
  end

endmodule
